csrfile: RTL
============

Name: csrfile

Overview:
Machine-mode CSR register file. It is the responder on the csrfile_req/csrfile_resp channel driven by the CSR execute unit.
- Decodes the 12-bit address combinationally, returns the old value and existence flag, and commits RW/RS/RC updates on handshake.
- Also owns mcycle/minstret, trap entry (mepc/mcause/mtval/mstatus) and mret.
- Exports mtvec/mepc/interrupt-pending to the fetch/commit logic.

Parameters:
HARTID, 32'd0, value returned by mhartid (0xF14).
MTVEC_RESET, 32'h0000_0000, reset value of mtvec (bits [1:0] forced 0).

Ports:
clk  in  1  clock.
rst  in  1  reset; asynchronous, active-low.
csrfile_req  decoupled.in  csr_req (a 12, d 32, t 2)  request from CSR execute unit.
csrfile_resp  out  csr_resp (exists 1, d 32)  combinational response for the current csrfile_req.data.
trap_valid  in  1  one-cycle pulse: take trap.
trap_cause  in  32  mcause value for the trap.
trap_pc  in  32  faulting/interrupted pc.
trap_tval  in  32  mtval value.
mret_valid  in  1  one-cycle pulse: execute mret.
instret  in  1  one instruction retired this cycle.
irq_ext, irq_timer, irq_soft  in  1 each  level interrupt lines (mip.MEIP/MTIP/MSIP).
mtvec_out  out  32  current mtvec.
mepc_out  out  32  current mepc.
intr_pending  out  1  mstatus.MIE && |(mip & mie).

Behaviour:
- Supported addresses:
  - 0x300 mstatus: MIE bit3, MPIE bit7, MPP[12:11] reads 2'b11; other bits read 0.
  - 0x301 misa: 32'h4000_0100; writes ignored.
  - 0x304 mie: bits 3/7/11 writable, others 0.
  - 0x305 mtvec: [1:0] forced 0.
  - 0x340 mscratch.
  - 0x341 mepc: [1:0] forced 0.
  - 0x342 mcause, 0x343 mtval.
  - 0x344 mip: read-only view of irq lines; writes ignored.
  - 0xB00/0xB80 mcycle lo/hi; 0xB02/0xB82 minstret lo/hi.
  - 0xC00/0xC80/0xC02/0xC82: read-only aliases of the counters.
  - 0xF11-0xF13: read 0. 0xF14: HARTID.
  - Any other address: resp.exists=0, resp.d=0.
- Response is purely combinational from csrfile_req.data and current state, independent of valid. resp.d is the pre-write value.
- Op t: 01 write d; 10 set (old|d); 11 clear (old&~d); 00 no write.
- Commit on valid&&ready; the new value is visible from the next cycle.
- Commit is a no-op when exists=0 or a[11:10]==2'b11.
- Commit is also a no-op when t is 10/11 and d==0.
- csrfile_req.ready = !trap_valid && !mret_valid. Requests stall during trap/mret cycles.
- Trap (trap_valid=1) updates these registers next edge:
  - mepc <= {trap_pc[31:2],2'b00}
  - mcause <= trap_cause
  - mtval <= trap_tval
  - MPIE <= MIE, MIE <= 0
- mret: MIE <= MPIE, MPIE <= 1.
- If trap_valid and mret_valid are both set, trap wins and mret is dropped.
- Counters are 64-bit; mcycle increments every cycle; minstret += instret.
- A CSR write to a counter half replaces that half. The other half is unaffected, except that a lo write carries nothing into hi. On the write cycle the write overrides the increment.
- Wrap: 64'hFFFF_FFFF_FFFF_FFFF + 1 -> 0. The lo half wraps 0xFFFF_FFFF -> 0 and hi increments in the same edge.
- Reset (asserted anytime, async) clears all registers to 0, except mtvec=MTVEC_RESET. Outputs are 0 / MTVEC_RESET during reset. An in-flight request is discarded.

Decomposition:
- Package csr_pkg holds:
  - csr_req (a, d, t) and csr_resp (exists, d) structs.
  - csr_op_t enum (NONE, RW, RS, RC).
  - localparam CSR_* addresses.
  - mstatus bit-index constants.
- One sub-module, csr_counter64: 64-bit counter with an increment input and independent lo/hi write ports. It is instantiated twice (mcycle, minstret).

Test Plan:
- After reset, req a=0x305, t=01, d=0x8000_0103 -> resp.d=0x0, exists=1. Next cycle mtvec_out=0x8000_0100.
- Write mscratch=0xF0F0_F0F0, then RC with d=0x00FF_00FF -> resp.d=0xF0F0_F0F0. Next read returns 0xF000_F000.
- Set mstatus MIE via RS d=0x8. Pulse trap_valid with pc=0x1002, cause=0xB -> mepc_out=0x1000, mcause=0xB, mstatus reads 0x1880. Then mret_valid -> mstatus reads 0x1888.
- Req a=0xC00, t=01, d=1 -> no commit, cycle keeps counting. Req a=0x7C0 -> exists=0, d=0.
- Write mcycle lo=0xFFFF_FFFE and hi=0x0000_0001 -> two cycles later mcycleh reads 0x0000_0002, mcycle reads 0x0000_0000.
- trap_valid and a valid RW to mscratch in the same cycle -> ready=0, mscratch unchanged. Request accepted the following cycle.

Source files
------------

// File: rtl/csr_pkg.sv
// ============================================================================
// Module : csr_pkg
// Desc   : Shared types, CSR addresses and mstatus bit positions for csrfile.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package csr_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RW   = 2'b01,
        OP_RS   = 2'b10,
        OP_RC   = 2'b11
    } csr_op_t;

    typedef struct packed {
        logic [11:0] a;
        logic [31:0] d;
        csr_op_t     t;
    } csr_req;

    typedef struct packed {
        logic        exists;
        logic [31:0] d;
    } csr_resp;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

    localparam logic [31:0] MISA_VALUE = 32'h4000_0100;
    localparam logic [31:0] MIE_MASK   = 32'h0000_0888;

endpackage

`default_nettype wire

// File: rtl/csr_counter64.sv
// ============================================================================
// Module : csr_counter64
// Desc   : 64-bit counter with increment and independent lo/hi write ports.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_inc,
    input  logic        i_wr_lo,
    input  logic        i_wr_hi,
    input  logic [31:0] i_wdata,
    output logic [63:0] o_value
);

    logic [31:0] r_lo;
    logic [31:0] r_hi;
    logic [32:0] w_lo_sum;

    assign w_lo_sum = {1'b0, r_lo} + {32'd0, i_inc};
    assign o_value  = {r_hi, r_lo};

    // A written half ignores the increment; a lo write never carries into hi,
    // and a hi write keeps lo counting but drops its carry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lo <= 32'd0;
            r_hi <= 32'd0;
        end else if (i_wr_lo) begin
            r_lo <= i_wdata;
        end else if (i_wr_hi) begin
            r_hi <= i_wdata;
            r_lo <= w_lo_sum[31:0];
        end else begin
            r_lo <= w_lo_sum[31:0];
            r_hi <= r_hi + {31'd0, w_lo_sum[32]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/csrfile.sv
// ============================================================================
// Module : csrfile
// Desc   : Machine-mode CSR register file with counters, trap entry and mret.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module csrfile
    import csr_pkg::*;
#(
    parameter logic [31:0] HARTID      = 32'd0,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csrfile_req_valid,
    output logic        csrfile_req_ready,
    input  csr_req      csrfile_req_data,
    output csr_resp     csrfile_resp,
    input  logic        trap_valid,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_tval,
    input  logic        mret_valid,
    input  logic        instret,
    input  logic        irq_ext,
    input  logic        irq_timer,
    input  logic        irq_soft,
    output logic [31:0] mtvec_out,
    output logic [31:0] mepc_out,
    output logic        intr_pending
);

    localparam logic [31:0] C_MTVEC_RST = MTVEC_RESET & ~32'h3;

    logic        r_mie_bit;
    logic        r_mpie;
    logic [31:0] r_mie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;

    logic [63:0] w_mcycle;
    logic [63:0] w_minstret;
    logic [31:0] w_mstatus;
    logic [31:0] w_mip;
    logic        w_fire;
    logic        w_wr_en;
    logic [31:0] w_wdata;

    assign w_mstatus = {19'd0, 2'b11, 3'd0, r_mpie, 3'd0, r_mie_bit, 3'd0};
    assign w_mip     = {20'd0, irq_ext, 3'd0, irq_timer, 3'd0, irq_soft, 3'd0};

    assign csrfile_req_ready = !trap_valid && !mret_valid;
    assign mtvec_out         = r_mtvec;
    assign mepc_out          = r_mepc;
    assign intr_pending      = r_mie_bit && |(w_mip & r_mie);

    always_comb begin
        csrfile_resp.exists = 1'b1;
        csrfile_resp.d      = 32'd0;
        case (csrfile_req_data.a)
            CSR_MSTATUS:                  csrfile_resp.d = w_mstatus;
            CSR_MISA:                     csrfile_resp.d = MISA_VALUE;
            CSR_MIE:                      csrfile_resp.d = r_mie;
            CSR_MTVEC:                    csrfile_resp.d = r_mtvec;
            CSR_MSCRATCH:                 csrfile_resp.d = r_mscratch;
            CSR_MEPC:                     csrfile_resp.d = r_mepc;
            CSR_MCAUSE:                   csrfile_resp.d = r_mcause;
            CSR_MTVAL:                    csrfile_resp.d = r_mtval;
            CSR_MIP:                      csrfile_resp.d = w_mip;
            CSR_MCYCLE,    CSR_CYCLE:     csrfile_resp.d = w_mcycle[31:0];
            CSR_MCYCLEH,   CSR_CYCLEH:    csrfile_resp.d = w_mcycle[63:32];
            CSR_MINSTRET,  CSR_INSTRET:   csrfile_resp.d = w_minstret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH:  csrfile_resp.d = w_minstret[63:32];
            CSR_MVENDORID, CSR_MARCHID,
            CSR_MIMPID:                   csrfile_resp.d = 32'd0;
            CSR_MHARTID:                  csrfile_resp.d = HARTID;
            default:                      csrfile_resp.exists = 1'b0;
        endcase
    end

    always_comb begin
        w_wdata = csrfile_req_data.d;
        case (csrfile_req_data.t)
            OP_RS:   w_wdata = csrfile_resp.d | csrfile_req_data.d;
            OP_RC:   w_wdata = csrfile_resp.d & ~csrfile_req_data.d;
            default: w_wdata = csrfile_req_data.d;
        endcase
    end

    // Set/clear with a zero mask must not disturb side-effecting registers.
    assign w_fire  = csrfile_req_valid && csrfile_req_ready;
    assign w_wr_en = w_fire && csrfile_resp.exists
                  && (csrfile_req_data.a[11:10] != 2'b11)
                  && (csrfile_req_data.t != OP_NONE)
                  && !((csrfile_req_data.t != OP_RW) && (csrfile_req_data.d == 32'd0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mie_bit  <= 1'b0;
            r_mpie     <= 1'b0;
            r_mie      <= 32'd0;
            r_mtvec    <= C_MTVEC_RST;
            r_mscratch <= 32'd0;
            r_mepc     <= 32'd0;
            r_mcause   <= 32'd0;
            r_mtval    <= 32'd0;
        end else if (trap_valid) begin
            r_mepc    <= trap_pc & ~32'h3;
            r_mcause  <= trap_cause;
            r_mtval   <= trap_tval;
            r_mpie    <= r_mie_bit;
            r_mie_bit <= 1'b0;
        end else if (mret_valid) begin
            r_mie_bit <= r_mpie;
            r_mpie    <= 1'b1;
        end else if (w_wr_en) begin
            case (csrfile_req_data.a)
                CSR_MSTATUS: begin
                    r_mie_bit <= w_wdata[MSTATUS_MIE_BIT];
                    r_mpie    <= w_wdata[MSTATUS_MPIE_BIT];
                end
                CSR_MIE:      r_mie      <= w_wdata & MIE_MASK;
                CSR_MTVEC:    r_mtvec    <= w_wdata & ~32'h3;
                CSR_MSCRATCH: r_mscratch <= w_wdata;
                CSR_MEPC:     r_mepc     <= w_wdata & ~32'h3;
                CSR_MCAUSE:   r_mcause   <= w_wdata;
                CSR_MTVAL:    r_mtval    <= w_wdata;
                default: ;
            endcase
        end
    end

    csr_counter64 u_mcycle (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (1'b1),
        .i_wr_lo (w_wr_en && (csrfile_req_data.a == CSR_MCYCLE)),
        .i_wr_hi (w_wr_en && (csrfile_req_data.a == CSR_MCYCLEH)),
        .i_wdata (w_wdata),
        .o_value (w_mcycle)
    );

    csr_counter64 u_minstret (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (instret),
        .i_wr_lo (w_wr_en && (csrfile_req_data.a == CSR_MINSTRET)),
        .i_wr_hi (w_wr_en && (csrfile_req_data.a == CSR_MINSTRETH)),
        .i_wdata (w_wdata),
        .o_value (w_minstret)
    );

endmodule

`default_nettype wire
